frame_wr_arbiter: RTL and testbench

//  Shares one framebuffer BRAM write port between the two OV7670 capture paths.

---
 rtl/frame_wr_arbiter_if.sv | 48 ++++
 rtl/frame_wr_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_frame_wr_arbiter.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/frame_wr_arbiter_if.sv
// rtl/frame_wr_arbiter_if.sv - camera-to-framebuffer write bus bundle
//
// Groups every signal between the two capture paths and the framebuffer
// write arbiter. Clock and reset stay outside as plain ports.
//   master : capture side (drives pixel requests and clr_err, sees status)
//   slave  : arbiter side (takes requests, drives status and the BRAM port)
//
// Signals
//   req_1/2, addr_1/2, pixel_1/2   per-camera pixel strobe, address, data
//   clr_err                        clears every sticky error flag
//   full_1/2                       camera FIFO holds its full depth
//   ovf_1/2                        sticky: pixel dropped because FIFO full
//   addr_err_1/2                   sticky: pixel dropped, address out of range
//   mem_we, mem_addr, mem_pixel    registered BRAM write port, addr = {cam_sel, addr}

interface frame_wr_arbiter_if #(
    parameter int c_nb_img_pxls = 15,
    parameter int c_nb_buf      = 12
);
    logic                     req_1;
    logic [c_nb_img_pxls-1:0] addr_1;
    logic [c_nb_buf-1:0]      pixel_1;
    logic                     req_2;
    logic [c_nb_img_pxls-1:0] addr_2;
    logic [c_nb_buf-1:0]      pixel_2;
    logic                     clr_err;
    logic                     full_1;
    logic                     full_2;
    logic                     ovf_1;
    logic                     ovf_2;
    logic                     addr_err_1;
    logic                     addr_err_2;
    logic                     mem_we;
    logic [c_nb_img_pxls:0]   mem_addr;
    logic [c_nb_buf-1:0]      mem_pixel;

    modport master (
        output req_1, addr_1, pixel_1, req_2, addr_2, pixel_2, clr_err,
        input  full_1, full_2, ovf_1, ovf_2, addr_err_1, addr_err_2,
        input  mem_we, mem_addr, mem_pixel
    );

    modport slave (
        input  req_1, addr_1, pixel_1, req_2, addr_2, pixel_2, clr_err,
        output full_1, full_2, ovf_1, ovf_2, addr_err_1, addr_err_2,
        output mem_we, mem_addr, mem_pixel
    );
endinterface

// File: rtl/frame_wr_arbiter.sv
// rtl/frame_wr_arbiter.sv - two-camera FIFO + round-robin framebuffer write arbiter
//
// Each camera pushes {addr, pixel} into its own small FIFO. A round-robin
// arbiter pops at most one head per clock onto a registered BRAM write port,
// prefixing the address with the camera-select bit so each image owns one
// half of the framebuffer.
//
// Ports
//   clk   in   rising-edge clock
//   rst   in   asynchronous active-high reset
//   bus   slave modport of frame_wr_arbiter_if (requests in, status and
//         BRAM write port out)

module frame_wr_arbiter #(
    parameter int c_img_pxls    = 19200,
    parameter int c_nb_img_pxls = 15,
    parameter int c_nb_buf      = 12,
    parameter int c_depth       = 4,
    parameter int c_nb_depth    = 2
) (
    input  logic              clk,
    input  logic              rst,
    frame_wr_arbiter_if.slave bus
);

    localparam int c_nb_ent = c_nb_img_pxls + c_nb_buf;

    localparam logic [c_nb_img_pxls-1:0] c_addr_lim = c_nb_img_pxls'(c_img_pxls);
    localparam logic [c_nb_depth:0]      c_full_cnt = (c_nb_depth + 1)'(c_depth);

    typedef enum logic {
        ARB_LAST1 = 1'b0,
        ARB_LAST2 = 1'b1
    } arb_state_t;

    // FIFO storage: entry = {addr, pixel}; no reset needed, pointers and
    // counts define validity.
    logic [c_nb_ent-1:0] fifo1_q [c_depth];
    logic [c_nb_ent-1:0] fifo2_q [c_depth];

    logic [c_nb_depth-1:0] wptr1_q, wptr1_d, rptr1_q, rptr1_d;
    logic [c_nb_depth-1:0] wptr2_q, wptr2_d, rptr2_q, rptr2_d;
    logic [c_nb_depth:0]   cnt1_q, cnt1_d, cnt2_q, cnt2_d;

    arb_state_t               state_q;
    logic                     we_q;
    logic [c_nb_img_pxls:0]   addr_q;
    logic [c_nb_buf-1:0]      pix_q;

    logic ovf1_q, ovf1_d, ovf2_q, ovf2_d;
    logic aerr1_q, aerr1_d, aerr2_q, aerr2_d;

    logic full1, full2, empty1, empty2;
    logic aerr_ev1, aerr_ev2, ovf_ev1, ovf_ev2;
    logic push1, push2, gnt1, gnt2;
    logic [c_nb_ent-1:0] head1, head2;

    assign full1  = (cnt1_q == c_full_cnt);
    assign full2  = (cnt2_q == c_full_cnt);
    assign empty1 = (cnt1_q == '0);
    assign empty2 = (cnt2_q == '0);

    assign head1 = fifo1_q[rptr1_q];
    assign head2 = fifo2_q[rptr2_q];

    // Address error outranks overflow; fullness is judged on the pre-edge
    // count, so a pop on the same edge cannot rescue a push into a full FIFO.
    assign aerr_ev1 = bus.req_1 & ~(bus.addr_1 < c_addr_lim);
    assign aerr_ev2 = bus.req_2 & ~(bus.addr_2 < c_addr_lim);
    assign ovf_ev1  = bus.req_1 & ~aerr_ev1 & full1;
    assign ovf_ev2  = bus.req_2 & ~aerr_ev2 & full2;
    assign push1    = bus.req_1 & ~aerr_ev1 & ~full1;
    assign push2    = bus.req_2 & ~aerr_ev2 & ~full2;

    // Grant from the pre-edge counts only: a pixel pushed this edge into an
    // empty FIFO is not visible to the arbiter until the next edge.
    always_comb begin
        gnt1 = 1'b0;
        gnt2 = 1'b0;
        if (!empty1 && !empty2) begin
            if (state_q == ARB_LAST1) begin
                gnt2 = 1'b1;
            end else begin
                gnt1 = 1'b1;
            end
        end else if (!empty1) begin
            gnt1 = 1'b1;
        end else if (!empty2) begin
            gnt2 = 1'b1;
        end
    end

    always_comb begin
        wptr1_d = push1 ? wptr1_q + 1'b1 : wptr1_q;
        wptr2_d = push2 ? wptr2_q + 1'b1 : wptr2_q;
        rptr1_d = gnt1 ? rptr1_q + 1'b1 : rptr1_q;
        rptr2_d = gnt2 ? rptr2_q + 1'b1 : rptr2_q;

        cnt1_d = cnt1_q;
        if (push1 && !gnt1) begin
            cnt1_d = cnt1_q + 1'b1;
        end else if (!push1 && gnt1) begin
            cnt1_d = cnt1_q - 1'b1;
        end

        cnt2_d = cnt2_q;
        if (push2 && !gnt2) begin
            cnt2_d = cnt2_q + 1'b1;
        end else if (!push2 && gnt2) begin
            cnt2_d = cnt2_q - 1'b1;
        end

        // Set wins over clear when both happen on the same edge.
        ovf1_d  = (ovf1_q  & ~bus.clr_err) | ovf_ev1;
        ovf2_d  = (ovf2_q  & ~bus.clr_err) | ovf_ev2;
        aerr1_d = (aerr1_q & ~bus.clr_err) | aerr_ev1;
        aerr2_d = (aerr2_q & ~bus.clr_err) | aerr_ev2;
    end

    always_ff @(posedge clk) begin
        if (push1) begin
            fifo1_q[wptr1_q] <= {bus.addr_1, bus.pixel_1};
        end
        if (push2) begin
            fifo2_q[wptr2_q] <= {bus.addr_2, bus.pixel_2};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr1_q <= '0;
            rptr1_q <= '0;
            cnt1_q  <= '0;
            wptr2_q <= '0;
            rptr2_q <= '0;
            cnt2_q  <= '0;
            ovf1_q  <= 1'b0;
            ovf2_q  <= 1'b0;
            aerr1_q <= 1'b0;
            aerr2_q <= 1'b0;
        end else begin
            wptr1_q <= wptr1_d;
            rptr1_q <= rptr1_d;
            cnt1_q  <= cnt1_d;
            wptr2_q <= wptr2_d;
            rptr2_q <= rptr2_d;
            cnt2_q  <= cnt2_d;
            ovf1_q  <= ovf1_d;
            ovf2_q  <= ovf2_d;
            aerr1_q <= aerr1_d;
            aerr2_q <= aerr2_d;
        end
    end

    // Arbiter state plus the registered write port. Reset leaves ARB_LAST2 so
    // camera 1 wins the first contention. Without a grant, address and data
    // hold so the BRAM inputs do not toggle needlessly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_LAST2;
            we_q    <= 1'b0;
            addr_q  <= '0;
            pix_q   <= '0;
        end else begin
            we_q <= gnt1 | gnt2;
            if (gnt1) begin
                state_q <= ARB_LAST1;
                addr_q  <= {1'b0, head1[c_nb_ent-1:c_nb_buf]};
                pix_q   <= head1[c_nb_buf-1:0];
            end else if (gnt2) begin
                state_q <= ARB_LAST2;
                addr_q  <= {1'b1, head2[c_nb_ent-1:c_nb_buf]};
                pix_q   <= head2[c_nb_buf-1:0];
            end
        end
    end

    assign bus.full_1     = full1;
    assign bus.full_2     = full2;
    assign bus.ovf_1      = ovf1_q;
    assign bus.ovf_2      = ovf2_q;
    assign bus.addr_err_1 = aerr1_q;
    assign bus.addr_err_2 = aerr2_q;
    assign bus.mem_we     = we_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_pixel  = pix_q;

endmodule

// File: tb/tb_frame_wr_arbiter.sv
// tb/tb_frame_wr_arbiter.sv - self-checking bench for frame_wr_arbiter

module tb_frame_wr_arbiter;

    localparam int c_img_pxls = 19200;
    localparam int c_depth    = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    frame_wr_arbiter_if bus ();

    frame_wr_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: one queue per camera of {addr, pixel}, last-granted camera.
    logic [26:0] q1[$];
    logic [26:0] q2[$];
    int          last_cam;
    logic        m_we;
    logic [15:0] m_addr;
    logic [11:0] m_pix;
    logic        m_ovf1, m_ovf2, m_aerr1, m_aerr2;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q1.delete();
        q2.delete();
        last_cam = 2;
        m_we     = 1'b0;
        m_addr   = '0;
        m_pix    = '0;
        m_ovf1   = 1'b0;
        m_ovf2   = 1'b0;
        m_aerr1  = 1'b0;
        m_aerr2  = 1'b0;
    endtask

    task automatic model_step();
        int          n1 = q1.size();
        int          n2 = q2.size();
        int          g = 0;
        logic [26:0] head = '0;
        bit          bad1, bad2;

        if (n1 > 0 && n2 > 0) g = (last_cam == 1) ? 2 : 1;
        else if (n1 > 0)      g = 1;
        else if (n2 > 0)      g = 2;

        bad1 = bus.req_1 && (int'(bus.addr_1) >= c_img_pxls);
        bad2 = bus.req_2 && (int'(bus.addr_2) >= c_img_pxls);
        m_aerr1 = (m_aerr1 && !bus.clr_err) || bad1;
        m_aerr2 = (m_aerr2 && !bus.clr_err) || bad2;
        m_ovf1  = (m_ovf1 && !bus.clr_err) || (bus.req_1 && !bad1 && n1 == c_depth);
        m_ovf2  = (m_ovf2 && !bus.clr_err) || (bus.req_2 && !bad2 && n2 == c_depth);

        if (g == 1) head = q1.pop_front();
        if (g == 2) head = q2.pop_front();
        if (g != 0) begin
            m_we     = 1'b1;
            m_addr   = {(g == 2), head[26:12]};
            m_pix    = head[11:0];
            last_cam = g;
        end else begin
            m_we = 1'b0;
        end

        if (bus.req_1 && !bad1 && n1 < c_depth) q1.push_back({bus.addr_1, bus.pixel_1});
        if (bus.req_2 && !bad2 && n2 < c_depth) q2.push_back({bus.addr_2, bus.pixel_2});
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".mem_we"},     32'(bus.mem_we),     32'(m_we));
        check_eq({tag, ".mem_addr"},   32'(bus.mem_addr),   32'(m_addr));
        check_eq({tag, ".mem_pixel"},  32'(bus.mem_pixel),  32'(m_pix));
        check_eq({tag, ".full_1"},     32'(bus.full_1),     32'(q1.size() == c_depth));
        check_eq({tag, ".full_2"},     32'(bus.full_2),     32'(q2.size() == c_depth));
        check_eq({tag, ".ovf_1"},      32'(bus.ovf_1),      32'(m_ovf1));
        check_eq({tag, ".ovf_2"},      32'(bus.ovf_2),      32'(m_ovf2));
        check_eq({tag, ".addr_err_1"}, 32'(bus.addr_err_1), 32'(m_aerr1));
        check_eq({tag, ".addr_err_2"}, 32'(bus.addr_err_2), 32'(m_aerr2));
    endtask

    // Inputs are set about 1 time unit after a rising edge; the model
    // predicts that edge, then outputs are sampled 1 unit after it.
    task automatic step(input string tag);
        if (rst) model_reset();
        else     model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle();
        bus.req_1   = 1'b0;
        bus.req_2   = 1'b0;
        bus.clr_err = 1'b0;
    endtask

    function automatic logic [14:0] rand_addr();
        if ($urandom_range(0, 15) == 0) return 15'($urandom_range(c_img_pxls, 32767));
        return 15'($urandom_range(0, c_img_pxls - 1));
    endfunction

    initial begin
        rst         = 1'b1;
        bus.req_1   = 1'b1;
        bus.req_2   = 1'b1;
        bus.addr_1  = 15'd3;
        bus.addr_2  = 15'd7;
        bus.pixel_1 = 12'h111;
        bus.pixel_2 = 12'h222;
        bus.clr_err = 1'b0;
        model_reset();

        // Reset held 3 clocks with both cameras requesting.
        for (int i = 0; i < 3; i++) step("rst_hold");
        check_eq("rst_we_zero", 32'(bus.mem_we), 32'd0);
        rst = 1'b0;
        idle();
        for (int i = 0; i < 2; i++) begin
            step("rst_release");
            check_eq("rst_no_we", 32'(bus.mem_we), 32'd0);
        end

        // Contention: both cameras push every clock for 8 clocks.
        for (int i = 0; i < 8; i++) begin
            bus.req_1   = 1'b1;
            bus.req_2   = 1'b1;
            bus.addr_1  = 15'($urandom_range(0, c_img_pxls - 1));
            bus.addr_2  = 15'($urandom_range(0, c_img_pxls - 1));
            bus.pixel_1 = 12'($urandom);
            bus.pixel_2 = 12'($urandom);
            step("contend");
            if (i >= 1) begin
                check_eq("contend_we", 32'(bus.mem_we), 32'd1);
                check_eq("contend_sel", 32'(bus.mem_addr[15]), 32'(i % 2 == 0));
            end
        end
        // After 8 edges: both FIFOs saturated, cam 1 popped on the last edge.
        check_eq("contend_ovf_1", 32'(bus.ovf_1), 32'd1);
        check_eq("contend_ovf_2", 32'(bus.ovf_2), 32'd1);
        check_eq("contend_full_1", 32'(bus.full_1), 32'd0);
        check_eq("contend_full_2", 32'(bus.full_2), 32'd1);

        // Reset mid-burst: asynchronous, clears the write port at once.
        #2;
        rst = 1'b1;
        #1;
        check_eq("rst_async_we", 32'(bus.mem_we), 32'd0);
        check_eq("rst_async_addr", 32'(bus.mem_addr), 32'd0);
        check_eq("rst_async_ovf_1", 32'(bus.ovf_1), 32'd0);
        model_reset();
        step("rst_mid");
        rst = 1'b0;
        idle();
        for (int i = 0; i < 4; i++) begin
            step("rst_mid_drain");
            check_eq("rst_mid_no_we", 32'(bus.mem_we), 32'd0);
        end

        // Single path: cam 1 addresses 0..4, one per clock.
        for (int a = 0; a < 5; a++) begin
            bus.req_1   = 1'b1;
            bus.addr_1  = 15'(a);
            bus.pixel_1 = 12'(12'hA00 + a);
            step("single");
            if (a >= 1) begin
                check_eq("single_we", 32'(bus.mem_we), 32'd1);
                check_eq("single_addr", 32'(bus.mem_addr), 32'(a - 1));
                check_eq("single_pix", 32'(bus.mem_pixel), 32'(12'hA00 + a - 1));
            end
        end
        idle();
        step("single_tail");
        check_eq("single_last_addr", 32'(bus.mem_addr), 32'd4);
        step("single_done");
        check_eq("single_done_we", 32'(bus.mem_we), 32'd0);

        // Address bound on cam 2.
        bus.req_2  = 1'b1;
        bus.addr_2 = 15'(c_img_pxls);
        bus.pixel_2 = 12'hBAD;
        step("addr_bad");
        check_eq("addr_err_2_set", 32'(bus.addr_err_2), 32'd1);
        idle();
        step("addr_bad_after");
        check_eq("addr_bad_no_we", 32'(bus.mem_we), 32'd0);
        bus.clr_err = 1'b1;
        step("addr_clr");
        check_eq("addr_err_2_clr", 32'(bus.addr_err_2), 32'd0);
        idle();

        // Last legal address is accepted.
        bus.req_2  = 1'b1;
        bus.addr_2 = 15'(c_img_pxls - 1);
        step("addr_max");
        idle();
        step("addr_max_wr");
        check_eq("addr_max_mem", 32'(bus.mem_addr), 32'(16'h8000 | (c_img_pxls - 1)));

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            bus.req_1   = ($urandom_range(0, 99) < 60);
            bus.req_2   = ($urandom_range(0, 99) < 60);
            bus.addr_1  = rand_addr();
            bus.addr_2  = rand_addr();
            bus.pixel_1 = 12'($urandom);
            bus.pixel_2 = 12'($urandom);
            bus.clr_err = ($urandom_range(0, 19) == 0);
            step("rand");
        end
        idle();
        for (int i = 0; i < 10; i++) step("rand_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
